jtag_scan_master: RTL and testbench
===================================

// Module: jtag_scan_master
// PURPOSE
//  Host-side JTAG master that sequences a target TAP controller (16-state, encoding 0=Test_Logic_Reset .. 15=Update_IR).
//  Accepts one command at a time (TAP reset, IR scan, DR scan, idle run) and generates the TMS/TDI bit stream.
//  Captures TDO during shift and returns it as a response.
//  Keeps a mirror of the target TAP state on tap_state_obs, using the same 4-bit encoding, for bench cross-checking.
// PARAMETERS
//  MAX_LEN  32  widest DR scan in bits; also the width of cmd_data and rsp_data
//  IR_LEN   4   instruction register length in bits; IR scans always shift exactly IR_LEN bits
// PORTS
//  clk            in   1        TCK-domain clock; all logic is rising-edge
//  TRST           in   1        asynchronous, active-high reset
//  cmd_valid      in   1        command offered
//  cmd_ready      out  1        master idle, can accept a command
//  cmd_type       in   2        00 TAP reset, 01 IR scan, 10 DR scan, 11 idle run
//  cmd_len        in   6        DR: bit count; idle: number of Run_Test_Idle cycles; ignored for reset and IR
//  cmd_data       in   MAX_LEN  TDI data, LSB shifted first; IR uses [IR_LEN-1:0]
//  rsp_valid      out  1        one-cycle pulse, command complete
//  rsp_data       out  MAX_LEN  captured TDO, LSB = first bit; bits >= shifted length are 0
//  rsp_err        out  1        qualified by rsp_valid; command rejected or compare failed
//  TMS            out  1        registered TMS to target
//  TDI            out  1        registered TDI to target
//  TDO            in   1        target TDO
//  tap_state_obs  out  4        mirrored target TAP state
//  busy           out  1        equals ~cmd_ready
// BEHAVIOUR
//  Reset values (async on TRST=1): TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0,
//   tap_state_obs=0 (Test_Logic_Reset), internal FSM=M_IDLE.
//  cmd_ready rises on the first clk edge after TRST falls.
//  Reset mid-command aborts the command: no rsp_valid is issued and the command is lost.
//  Handshake:
//   - Accept on clk edge with cmd_valid & cmd_ready; cmd_* fields are latched and cmd_ready drops the next cycle.
//   - rsp_valid pulses exactly once per accepted command; rsp_data/rsp_err hold until the next response.
//   - cmd_ready reasserts the cycle after the rsp_valid pulse.
//   - There is no response backpressure.
//  TMS/TDI change only on clk edges; the target consumes them on the following edge.
//  tap_state_obs updates on that same consuming edge, using standard TAP transitions of the TMS just consumed.
//  FSM states:
//   - M_IDLE: TMS=0 if mirror is Run_Test_Idle, else TMS=1; no state change.
//   - M_RESET: 5 cycles TMS=1 then 1 cycle TMS=0; ends in Run_Test_Idle.
//   - M_TO_RTI: inserted when an IR/DR/idle command starts with mirror=Test_Logic_Reset; 1 cycle TMS=0.
//   - M_SEL: from Run_Test_Idle.
//       DR: TMS 1,0,0 (Select_DR, Capture_DR, Shift_DR).
//       IR: TMS 1,1,0,0 (Select_DR, Select_IR, Capture_IR, Shift_IR).
//   - M_SHIFT: N bits, TDI = data[k]; TMS=0 except on the last bit, where TMS=1 (Exit1).
//       TDO is sampled into rsp_data[k] on the edge that consumes bit k.
//   - M_EXIT: TMS 1 (Update), then 0 (Run_Test_Idle).
//   - M_RUN: cmd_len cycles TMS=0 (idle run).
//   - M_DONE: rsp_valid=1 for one cycle.
//  TMS cycle counts from Run_Test_Idle: DR = 5+len; IR = 6+IR_LEN; idle = len; reset = 6.
//   Add 1 cycle when starting from Test_Logic_Reset.
//  Boundary conditions:
//   - DR len=0 or len>MAX_LEN: no TMS activity; M_DONE with rsp_err=1, rsp_data=0.
//   - idle len=0: M_DONE the cycle after acceptance, rsp_err=0.
//   - cmd_valid while busy: ignored, not latched.
//  Bit counter is 6 bits and never wraps; N is at most MAX_LEN, with MAX_LEN <= 63.
// CONFIGURATION
//  Macro JTAG_SCAN_CHECK_EN.
//  Defined:
//   - Adds inputs cmd_expect[MAX_LEN-1:0] and cmd_mask[MAX_LEN-1:0], latched at acceptance.
//   - rsp_err is also set when ((rsp_data ^ expect) & mask) != 0.
//   - The mask applies only to shifted bits.
//  Undefined:
//   - These ports do not exist.
//   - rsp_err is set only for rejected lengths.
// TESTING  (IR_LEN=4, MAX_LEN=32; bench target = TAP model + 4-bit IR + 8-bit DR shift regs with reset contents)
//  1. After TRST, reset cmd -> TMS 1,1,1,1,1,0; tap_state_obs ends 1; rsp_valid 1 pulse, rsp_err=0.
//  2. IR scan data=4'hA from RTI -> 10 TMS cycles; target IR=4'hA at Update_IR (state 15);
//     rsp_data = prior IR value; ends state 1.
//  3. DR scan len=8 data=8'h5C, target DR=8'h3E -> rsp_data=32'h3E; target DR=8'h5C; 13 cycles.
//  4. DR len=0, then len=33 -> each rsp_err=1, rsp_data=0, TMS held 0, tap_state_obs stays 1.
//  5. TRST pulse mid-DR shift (bit 3) -> TMS=1, tap_state_obs=0, no rsp_valid.
//     Next DR scan len=8 inserts M_TO_RTI (14 cycles).
//  6. With JTAG_SCAN_CHECK_EN: DR len=8, expect=8'h3F, mask=8'h01, TDO 8'h3E -> rsp_err=1;
//     mask=8'hFE -> rsp_err=0.

Source files
------------

// File: rtl/jtag_scan_master.sv
// jtag_scan_master
//   Host-side JTAG master. Accepts one command at a time (TAP reset, IR scan,
//   DR scan, idle run), drives a registered TMS/TDI stream into the target TAP,
//   captures TDO while shifting and returns it as a single-cycle response.
//   A mirror of the target TAP state (0=Test_Logic_Reset .. 15=Update_IR) is
//   kept on tap_state_obs.
//
//   Optional feature: define JTAG_SCAN_CHECK_EN to add cmd_expect/cmd_mask
//   inputs; rsp_err is then also raised when masked shifted bits of the
//   captured data differ from the expected value.
//
// Ports
//   clk            TCK-domain clock, rising edge
//   TRST           asynchronous active-high reset
//   cmd_valid      command offered
//   cmd_ready      master idle, command accepted when valid & ready
//   cmd_type       00 TAP reset, 01 IR scan, 10 DR scan, 11 idle run
//   cmd_len        DR bit count / idle Run_Test_Idle cycle count
//   cmd_data       TDI data, LSB shifted first
//   cmd_expect     (JTAG_SCAN_CHECK_EN) expected TDO data
//   cmd_mask       (JTAG_SCAN_CHECK_EN) compare mask
//   rsp_valid      one-cycle completion pulse
//   rsp_data       captured TDO, LSB = first bit shifted
//   rsp_err        rejected command or compare failure
//   TMS, TDI       registered outputs to target
//   TDO            target data out
//   tap_state_obs  mirrored target TAP state
//   busy           ~cmd_ready
module jtag_scan_master #(
    parameter int MAX_LEN = 32,
    parameter int IR_LEN  = 4
) (
    input  logic               clk,
    input  logic               TRST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_SCAN_CHECK_EN
    input  logic [MAX_LEN-1:0] cmd_expect,
    input  logic [MAX_LEN-1:0] cmd_mask,
`endif
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO,
    output logic [3:0]         tap_state_obs,
    output logic               busy
);

    typedef enum logic [3:0] {
        TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EX1_DR,
        TAP_PAUSE_DR, TAP_EX2_DR, TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR,
        TAP_SHIFT_IR, TAP_EX1_IR, TAP_PAUSE_IR, TAP_EX2_IR, TAP_UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {
        CMD_RESET, CMD_IR, CMD_DR, CMD_RUN
    } cmd_t;

    typedef enum logic [2:0] {
        M_IDLE, M_RESET, M_TO_RTI, M_SEL, M_SHIFT, M_EXIT, M_RUN, M_DONE
    } mstate_t;

    localparam logic [MAX_LEN-1:0] ALL_ONES = '1;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TAP_TLR;
        case (s)
            TAP_TLR:      n = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   n = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   n = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: n = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
            TAP_EX1_DR:   n = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: n = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   n = tms ? TAP_UPD_DR : TAP_SHIFT_DR;
            TAP_UPD_DR:   n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   n = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   n = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: n = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
            TAP_EX1_IR:   n = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: n = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   n = tms ? TAP_UPD_IR : TAP_SHIFT_IR;
            TAP_UPD_IR:   n = tms ? TAP_SEL_DR : TAP_RTI;
            default:      n = TAP_TLR;
        endcase
        return n;
    endfunction

    mstate_t            state, state_next;
    tap_state_t         tap, tap_nxt;
    logic [5:0]         cnt;
    cmd_t               lat_typ;
    logic [5:0]         lat_len;
    logic [MAX_LEN-1:0] data_sh;
    logic [MAX_LEN-1:0] cap;
    logic               samp_en;
    logic [5:0]         samp_idx;
    logic [5:0]         nbits;
    logic               last_bit;
    logic               accept;
    logic               dr_bad;
    logic               mis;
    logic               tms_d, tdi_d;
    logic [MAX_LEN-1:0] rsp_data_d;
    logic               rsp_err_d;
`ifdef JTAG_SCAN_CHECK_EN
    logic [MAX_LEN-1:0] lat_expect;
    logic [MAX_LEN-1:0] lat_mask;
`endif

    assign accept        = cmd_valid && cmd_ready && (state == M_IDLE);
    assign dr_bad        = (cmd_len == 6'd0) || ({1'b0, cmd_len} > 7'(MAX_LEN));
    assign tap_nxt       = tap_next(tap, TMS);
    assign tap_state_obs = tap;
    assign busy          = ~cmd_ready;
    assign nbits         = (lat_typ == CMD_IR) ? 6'(IR_LEN) :
                           (lat_typ == CMD_DR) ? lat_len : 6'd0;
    assign last_bit      = (cnt == nbits - 6'd1);

`ifdef JTAG_SCAN_CHECK_EN
    assign mis = |((cap ^ lat_expect) & lat_mask & ~(ALL_ONES << nbits));
`else
    assign mis = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge TRST) begin
        if (TRST) state <= M_IDLE;
        else      state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            M_IDLE: begin
                if (accept) begin
                    case (cmd_type)
                        CMD_RESET: state_next = M_RESET;
                        CMD_IR:    state_next = (tap == TAP_TLR) ? M_TO_RTI : M_SEL;
                        CMD_DR: begin
                            if (dr_bad)              state_next = M_DONE;
                            else if (tap == TAP_TLR) state_next = M_TO_RTI;
                            else                     state_next = M_SEL;
                        end
                        default: begin
                            if (cmd_len == 6'd0)     state_next = M_DONE;
                            else if (tap == TAP_TLR) state_next = M_TO_RTI;
                            else                     state_next = M_RUN;
                        end
                    endcase
                end
            end
            M_RESET:  if (cnt == 6'd5) state_next = M_DONE;
            M_TO_RTI: state_next = (lat_typ == CMD_RUN) ? M_RUN : M_SEL;
            M_SEL:    if (cnt == ((lat_typ == CMD_IR) ? 6'd3 : 6'd2)) state_next = M_SHIFT;
            M_SHIFT:  if (last_bit) state_next = M_EXIT;
            M_EXIT:   if (cnt == 6'd1) state_next = M_DONE;
            M_RUN:    if (cnt == lat_len - 6'd1) state_next = M_DONE;
            M_DONE:   state_next = M_IDLE;
            default:  state_next = M_IDLE;
        endcase
    end

    // Output logic: value TMS/TDI take at the next edge, and response contents
    always_comb begin
        tms_d      = 1'b0;
        tdi_d      = 1'b0;
        rsp_data_d = cap;
        rsp_err_d  = mis;
        case (state)
            // Park: hold the TAP where the mirror is about to be
            M_IDLE, M_DONE: tms_d = (tap_nxt != TAP_RTI);
            M_RESET:        tms_d = (cnt != 6'd5);
            M_TO_RTI:       tms_d = 1'b0;
            M_SEL:          tms_d = (lat_typ == CMD_IR) ? (cnt < 6'd2) : (cnt == 6'd0);
            M_SHIFT: begin
                tms_d = last_bit;
                tdi_d = data_sh[0];
            end
            M_EXIT:         tms_d = (cnt == 6'd0);
            default:        tms_d = 1'b0;
        endcase
        // Direct IDLE->DONE only happens for rejected DR lengths or zero-length idle
        if (state == M_IDLE) begin
            rsp_data_d = '0;
            rsp_err_d  = (cmd_type == CMD_DR);
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge TRST) begin
        if (TRST) begin
            TMS        <= 1'b1;
            TDI        <= 1'b0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            tap        <= TAP_TLR;
            cnt        <= '0;
            lat_typ    <= CMD_RESET;
            lat_len    <= '0;
            data_sh    <= '0;
            cap        <= '0;
            samp_en    <= 1'b0;
            samp_idx   <= '0;
`ifdef JTAG_SCAN_CHECK_EN
            lat_expect <= '0;
            lat_mask   <= '0;
`endif
        end else begin
            TMS       <= tms_d;
            TDI       <= tdi_d;
            tap       <= tap_nxt;
            cmd_ready <= (state_next == M_IDLE);
            rsp_valid <= (state_next == M_DONE);

            if (state_next != state || state == M_IDLE) cnt <= '0;
            else                                       cnt <= cnt + 6'd1;

            if (accept) begin
                lat_typ    <= cmd_t'(cmd_type);
                lat_len    <= cmd_len;
                data_sh    <= cmd_data;
`ifdef JTAG_SCAN_CHECK_EN
                lat_expect <= cmd_expect;
                lat_mask   <= cmd_mask;
`endif
            end else if (state == M_SHIFT) begin
                data_sh <= data_sh >> 1;
            end

            // TDO for bit k is taken on the edge after TDI=bit k was launched
            samp_en  <= (state == M_SHIFT);
            samp_idx <= cnt;
            if (accept)       cap <= '0;
            else if (samp_en) cap <= cap | ({{(MAX_LEN-1){1'b0}}, TDO} << samp_idx);

            if (state_next == M_DONE) begin
                rsp_data <= rsp_data_d;
                rsp_err  <= rsp_err_d;
            end
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master
//   Directed bench for jtag_scan_master (MAX_LEN=32, IR_LEN=4) driving a
//   behavioural TAP target with a 4-bit IR (reset 4'h1) and 8-bit DR
//   (reset 8'h3E). Define JTAG_SCAN_CHECK_EN to cover the compare feature.
module tb_jtag_scan_master;

    localparam logic [3:0] S_TLR = 4'd0,  S_RTI = 4'd1,  S_SELDR = 4'd2,  S_CAPDR = 4'd3;
    localparam logic [3:0] S_SHDR = 4'd4, S_E1DR = 4'd5, S_PADR = 4'd6,   S_E2DR = 4'd7;
    localparam logic [3:0] S_UPDR = 4'd8, S_SELIR = 4'd9, S_CAPIR = 4'd10, S_SHIR = 4'd11;
    localparam logic [3:0] S_E1IR = 4'd12, S_PAIR = 4'd13, S_E2IR = 4'd14, S_UPIR = 4'd15;

    logic        clk = 1'b0;
    logic        TRST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
`ifdef JTAG_SCAN_CHECK_EN
    logic [31:0] cmd_expect;
    logic [31:0] cmd_mask;
`endif
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        TMS, TDI, TDO;
    logic [3:0]  tap_state_obs;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit mon_en = 0;

    always #5 clk = ~clk;

    jtag_scan_master #(.MAX_LEN(32), .IR_LEN(4)) dut (
        .clk           (clk),
        .TRST          (TRST),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_type      (cmd_type),
        .cmd_len       (cmd_len),
        .cmd_data      (cmd_data),
`ifdef JTAG_SCAN_CHECK_EN
        .cmd_expect    (cmd_expect),
        .cmd_mask      (cmd_mask),
`endif
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .TMS           (TMS),
        .TDI           (TDI),
        .TDO           (TDO),
        .tap_state_obs (tap_state_obs),
        .busy          (busy)
    );

    // Behavioural target TAP
    logic [3:0] tst;
    logic [3:0] ir, ir_sh;
    logic [7:0] dr, dr_sh;
    int         upd_ir_cnt = 0;

    assign TDO = (tst == S_SHIR) ? ir_sh[0] : (tst == S_SHDR) ? dr_sh[0] : 1'b0;

    always @(posedge clk or posedge TRST) begin
        if (TRST) begin
            tst   <= S_TLR;
            ir    <= 4'h1;
            dr    <= 8'h3E;
            ir_sh <= 4'h0;
            dr_sh <= 8'h00;
        end else begin
            if (tst == S_CAPDR) dr_sh <= dr;
            if (tst == S_SHDR)  dr_sh <= {TDI, dr_sh[7:1]};
            if (tst == S_UPDR)  dr    <= dr_sh;
            if (tst == S_CAPIR) ir_sh <= ir;
            if (tst == S_SHIR)  ir_sh <= {TDI, ir_sh[3:1]};
            if (tst == S_UPIR) begin
                ir <= ir_sh;
                upd_ir_cnt <= upd_ir_cnt + 1;
            end
            if (tst == S_TLR)        tst <= TMS ? S_TLR   : S_RTI;
            else if (tst == S_RTI)   tst <= TMS ? S_SELDR : S_RTI;
            else if (tst == S_SELDR) tst <= TMS ? S_SELIR : S_CAPDR;
            else if (tst == S_SELIR) tst <= TMS ? S_TLR   : S_CAPIR;
            else if (tst == S_CAPDR || tst == S_SHDR) tst <= TMS ? S_E1DR : S_SHDR;
            else if (tst == S_CAPIR || tst == S_SHIR) tst <= TMS ? S_E1IR : S_SHIR;
            else if (tst == S_E1DR)  tst <= TMS ? S_UPDR : S_PADR;
            else if (tst == S_E1IR)  tst <= TMS ? S_UPIR : S_PAIR;
            else if (tst == S_PADR)  tst <= TMS ? S_E2DR : S_PADR;
            else if (tst == S_PAIR)  tst <= TMS ? S_E2IR : S_PAIR;
            else if (tst == S_E2DR)  tst <= TMS ? S_UPDR : S_SHDR;
            else if (tst == S_E2IR)  tst <= TMS ? S_UPIR : S_SHIR;
            else                     tst <= TMS ? S_SELDR : S_RTI;  // Update_DR / Update_IR
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) pulses++;
        if (mon_en) check("tap_mirror", tap_state_obs, tst);
    end

    // Issues one command, returns response, latency (edges from acceptance to
    // rsp_valid) and the TMS stream launched after acceptance (oldest bit high).
    task automatic run_cmd(input logic [1:0] typ, input logic [5:0] len, input logic [31:0] data,
                           output logic [31:0] rdata, output logic rerr, output int lat,
                           output logic [63:0] tlog);
        int guard;
        guard = 0;
        rdata = '0;
        rerr  = 1'b0;
        lat   = -1;
        tlog  = '0;
        @(negedge clk);
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", cmd_ready, 1);
        cmd_type  = typ;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        // Keep offering junk while busy: must not be latched or accepted
        cmd_type = 2'b00;
        cmd_len  = 6'h3F;
        cmd_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("busy_after_accept", {cmd_ready, busy}, 2'b01);
        for (int k = 0; k < 200; k++) begin
            if (k > 0) tlog = {tlog[62:0], TMS};
            if (rsp_valid) begin
                lat   = k;
                rdata = rsp_data;
                rerr  = rsp_err;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (lat < 0) check("rsp_timeout", 0, 1);
        @(negedge clk);
        check("rsp_pulse_end", rsp_valid, 0);
        check("ready_again", cmd_ready, 1);
    endtask

    logic [31:0] rd;
    logic        re;
    int          lt;
    logic [63:0] tl;
    int          p0;

    initial begin
        TRST      = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
        cmd_len   = 6'd0;
        cmd_data  = '0;
`ifdef JTAG_SCAN_CHECK_EN
        cmd_expect = '0;
        cmd_mask   = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_tms", TMS, 1);
        check("rst_tdi", TDI, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 34'h0);
        check("rst_tap", tap_state_obs, 0);
        TRST   = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", cmd_ready, 1);

        // 1. TAP reset command
        run_cmd(2'b00, 6'd0, 32'h0, rd, re, lt, tl);
        check("reset_lat", lt, 6);
        check("reset_tms", tl & 64'h3F, 64'h3E);
        check("reset_err", re, 0);
        check("reset_end_tap", tap_state_obs, 1);

        // 2. IR scan 4'hA
        p0 = upd_ir_cnt;
        run_cmd(2'b01, 6'd0, 32'h0000_000A, rd, re, lt, tl);
        check("ir_lat", lt, 10);
        check("ir_tms", tl & 64'h3FF, 64'h306);
        check("ir_rdata", rd, 32'h1);
        check("ir_err", re, 0);
        check("ir_target", ir, 4'hA);
        check("ir_update_seen", upd_ir_cnt - p0, 1);
        check("ir_end_tap", tap_state_obs, 1);

        // 3. DR scan len 8
        run_cmd(2'b10, 6'd8, 32'h0000_005C, rd, re, lt, tl);
        check("dr_lat", lt, 13);
        check("dr_tms", tl & 64'h1FFF, 64'h1006);
        check("dr_rdata", rd, 32'h3E);
        check("dr_err", re, 0);
        check("dr_target", dr, 8'h5C);

        // 4. Rejected DR lengths
        run_cmd(2'b10, 6'd0, 32'h0000_00FF, rd, re, lt, tl);
        check("dr0_lat", lt, 0);
        check("dr0_rsp", {re, rd}, 33'h1_0000_0000);
        check("dr0_tms", TMS, 0);
        check("dr0_tap", tap_state_obs, 1);
        run_cmd(2'b10, 6'd33, 32'hFFFF_FFFF, rd, re, lt, tl);
        check("dr33_lat", lt, 0);
        check("dr33_rsp", {re, rd}, 33'h1_0000_0000);
        check("dr33_tms", TMS, 0);
        check("dr33_tap", tap_state_obs, 1);
        check("dr_target_kept", dr, 8'h5C);

        // Idle runs
        run_cmd(2'b11, 6'd0, 32'h0, rd, re, lt, tl);
        check("idle0_lat", lt, 0);
        check("idle0_err", re, 0);
        run_cmd(2'b11, 6'd3, 32'h0, rd, re, lt, tl);
        check("idle3_lat", lt, 3);
        check("idle3_tms", tl & 64'h7, 64'h0);
        check("idle3_rsp", {re, rd}, 33'h0);
        check("idle3_tap", tap_state_obs, 1);

        // 5. TRST mid DR shift
        p0 = pulses;
        @(negedge clk);
        cmd_type  = 2'b10;
        cmd_len   = 6'd8;
        cmd_data  = 32'h0000_00A5;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_in_shift", tap_state_obs, S_SHDR);
        TRST = 1'b1;
        #1;
        check("abort_tms", TMS, 1);
        check("abort_tap", tap_state_obs, 0);
        check("abort_ready", cmd_ready, 0);
        @(negedge clk);
        TRST = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_rsp", pulses - p0, 0);
        check("abort_tap_hold", tap_state_obs, 0);
        run_cmd(2'b10, 6'd8, 32'h0000_005C, rd, re, lt, tl);
        check("dr_tlr_lat", lt, 14);
        check("dr_tlr_tms", tl & 64'h3FFF, 64'h1006);
        check("dr_tlr_rdata", rd, 32'h3E);
        check("dr_tlr_target", dr, 8'h5C);

`ifdef JTAG_SCAN_CHECK_EN
        // 6. Compare feature
        @(negedge clk);
        TRST = 1'b1;
        @(negedge clk);
        TRST = 1'b0;
        cmd_expect = 32'h0000_003F;
        cmd_mask   = 32'h0000_0001;
        run_cmd(2'b10, 6'd8, 32'h0000_003E, rd, re, lt, tl);
        check("cmp_rdata", rd, 32'h3E);
        check("cmp_err_set", re, 1);
        cmd_mask = 32'h0000_00FE;
        run_cmd(2'b10, 6'd8, 32'h0000_003E, rd, re, lt, tl);
        check("cmp_err_clear", re, 0);
        check("rsp_pulses", pulses, 10);
`else
        check("rsp_pulses", pulses, 8);
`endif

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
